// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// A round-robin grant picks a requester in IDLE. Its operands and opcode are
// latched and drive the ALU for one cycle (EXEC). The result and zero flag are
// registered and held on a tagged response channel (RESP) until it is accepted.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req{0,1}_valid/_ready      request handshake per requester
//   req{0,1}_a/_b/_op          operands and ALU control code
//   alu_a/alu_b/alu_ctrl       latched operands/opcode to the ALU
//   alu_y/alu_z                ALU result and zero flag
//   rsp_valid/rsp_ready        response handshake
//   rsp_id/rsp_y/rsp_z         issuing requester, registered result and zero flag
//   busy                       high whenever an operation is in flight
module alu_arbiter #(
  parameter int   DATA_W    = 32,
  parameter int   OP_W      = 3,
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_ctrl,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_z,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_y,
  output logic              rsp_z,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } req_t;

  state_t            state, nxt;
  req_t [1:0]        req_in;
  logic [1:0]        req_vld;
  logic [1:0]        gnt;
  req_t              op_q;
  logic              id_q;
  logic              rr_q;
  logic [DATA_W-1:0] y_q;
  logic              z_q;

  assign req_in[0] = {req0_a, req0_b, req0_op};
  assign req_in[1] = {req1_a, req1_b, req1_op};
  assign req_vld   = {req1_valid, req0_valid};

  // Grant is only offered in IDLE and never while reset is held, so a
  // requester sitting on valid through reset sees ready low.
  always_comb begin
    gnt = 2'b00;
    if (state == IDLE && rst_n) begin
      if (req_vld[0] && (!req_vld[1] || !rr_q)) gnt[0] = 1'b1;
      else if (req_vld[1])                      gnt[1] = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (|gnt)     nxt = EXEC;
      EXEC:                  nxt = RESP;
      RESP:    if (rsp_ready) nxt = IDLE;
      default:               nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req0_ready = gnt[0];
    req1_ready = gnt[1];
    rsp_valid  = (state == RESP);
    busy       = (state != IDLE);
  end

  // Datapath: latch the granted request, capture the ALU result in EXEC,
  // and hand priority to the other requester once the response is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      id_q <= 1'b0;
      y_q  <= '0;
      z_q  <= 1'b0;
      rr_q <= PRIO_INIT;
    end else begin
      if (state == IDLE && |gnt) begin
        op_q <= req_in[gnt[1]];
        id_q <= gnt[1];
      end
      if (state == EXEC) begin
        y_q <= alu_y;
        z_q <= alu_z;
      end
      if (state == RESP && rsp_ready) rr_q <= ~id_q;
    end
  end

  assign alu_a    = op_q.a;
  assign alu_b    = op_q.b;
  assign alu_ctrl = op_q.op;
  assign rsp_id   = id_q;
  assign rsp_y    = y_q;
  assign rsp_z    = z_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int OW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OW-1:0] req0_op, req1_op;
  logic [DW-1:0] alu_a, alu_b, alu_y;
  logic [OW-1:0] alu_ctrl;
  logic          alu_z;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_z, busy;
  logic [DW-1:0] rsp_y;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DW), .OP_W(OW), .PRIO_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_y(alu_y), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_z(rsp_z), .busy(busy)
  );

  // Behavioural ALU
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_y = alu_a + alu_b;
      3'b001:  alu_y = alu_a - alu_b;
      3'b010:  alu_y = alu_a & alu_b;
      3'b011:  alu_y = alu_a | alu_b;
      3'b100:  alu_y = alu_a ^ alu_b;
      default: alu_y = ~alu_a;
    endcase
    alu_z = (alu_y == '0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; #1;
    @(negedge clk); rst_n = 1'b1; #1;
  endtask

  initial begin
    int n, last;
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, last;
    rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;

    // 1: reset with both requesters valid
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("t1_rdy0", req0_ready, 0);
    chk("t1_rdy1", req1_ready, 0);
    chk("t1_rspv", rsp_valid, 0);
    chk("t1_busy", busy, 0);
    chk("t1_alua", alu_a, 0);
    chk("t1_alub", alu_b, 0);
    chk("t1_ctrl", alu_ctrl, 0);
    rst_n = 1'b1; #1;
    chk("t1_gnt0", req0_ready, 1);
    chk("t1_gnt1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0; // withdrawn before the edge
    @(negedge clk); #1;
    chk("t1_nosrv", busy, 0);

    // 2: single op from requester 0
    req0_a = 5; req0_b = 7; req0_op = 3'b000; req0_valid = 1'b1; rsp_ready = 1'b1; #1;
    chk("t2_rdy0", req0_ready, 1);
    @(negedge clk); req0_valid = 1'b0; #1;
    chk("t2_busy", busy, 1);
    chk("t2_alua", alu_a, 5);
    chk("t2_alub", alu_b, 7);
    chk("t2_ctrl", alu_ctrl, 0);
    chk("t2_rspv0", rsp_valid, 0);
    @(negedge clk); #1;
    chk("t2_rspv", rsp_valid, 1);
    chk("t2_id", rsp_id, 0);
    chk("t2_y", rsp_y, 12);
    chk("t2_z", rsp_z, 0);
    @(negedge clk); #1;
    chk("t2_idle", busy, 0);
    chk("t2_rspv_off", rsp_valid, 0);

    // 3: contention from reset
    do_reset();
    req0_a = 9; req0_b = 9; req0_op = 3'b001;
    req1_a = 32'h0F; req1_b = 32'hF0; req1_op = 3'b011;
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    chk("t3_rdy0", req0_ready, 1);
    chk("t3_rdy1", req1_ready, 0);
    @(negedge clk); req0_valid = 1'b0; #1;
    @(negedge clk); #1;
    chk("t3_r1v", rsp_valid, 1);
    chk("t3_r1id", rsp_id, 0);
    chk("t3_r1y", rsp_y, 0);
    chk("t3_r1z", rsp_z, 1);
    chk("t3_r1rdy1", req1_ready, 0);
    @(negedge clk); #1;
    chk("t3_gnt1", req1_ready, 1);
    @(negedge clk); req1_valid = 1'b0; #1;
    @(negedge clk); #1;
    chk("t3_r2id", rsp_id, 1);
    chk("t3_r2y", rsp_y, 32'hFF);
    chk("t3_r2z", rsp_z, 0);
    @(negedge clk); #1;
    chk("t3_idle", busy, 0);

    // 4: backpressure
    do_reset();
    rsp_ready = 1'b0;
    req1_a = 32'hFF00; req1_b = 32'h0FF0; req1_op = 3'b010; req1_valid = 1'b1; #1;
    chk("t4_rdy1", req1_ready, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    req0_a = 1; req0_b = 2; req0_op = 3'b000; req0_valid = 1'b1; #1;
    chk("t4_exec_rdy0", req0_ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("t4_rspv", rsp_valid, 1);
      chk("t4_y", rsp_y, 32'h0F00);
      chk("t4_id", rsp_id, 1);
      chk("t4_rdy0", req0_ready, 0);
      chk("t4_rdy1", req1_ready, 0);
      chk("t4_busy", busy, 1);
    end
    rsp_ready = 1'b1; #1;
    chk("t4_same_cyc_rdy0", req0_ready, 0);
    @(negedge clk); #1;
    chk("t4_idle", busy, 0);
    chk("t4_rspv_off", rsp_valid, 0);
    chk("t4_next_gnt0", req0_ready, 1);
    req0_valid = 1'b0;
    @(negedge clk); #1;
    chk("t4_quiet", busy, 0);

    // 5: fairness, both continuously valid
    do_reset();
    req0_a = 1;  req0_b = 2; req0_op = 3'b000;  // y = 3
    req1_a = 10; req1_b = 4; req1_op = 3'b001;  // y = 6
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    n = 0; last = 0;
    for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
      @(negedge clk); #1;
      if (rsp_valid) begin
        chk("t5_id", rsp_id, n % 2);
        chk("t5_y", rsp_y, (n % 2) ? 6 : 3);
        if (n > 0) chk("t5_period", cyc - last, 3);
        last = cyc;
        n++;
      end
    end
    chk("t5_count", n, 6);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); @(negedge clk); #1;

    // 6: reset during EXEC of a req1 op, with the pointer moved to 1 first
    do_reset();
    req0_a = 2; req0_b = 2; req0_op = 3'b000; req0_valid = 1'b1; #1;
    @(negedge clk); req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("t6_pre_idle", busy, 0);
    req1_a = 3; req1_b = 4; req1_op = 3'b100; req1_valid = 1'b1; #1;
    chk("t6_rdy1", req1_ready, 1);
    @(negedge clk); req1_valid = 1'b0; #1;
    chk("t6_exec", busy, 1);
    chk("t6_alua", alu_a, 3);
    rst_n = 1'b0; #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_alua", alu_a, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("t6_no_rsp", rsp_valid, 0);
    end
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    chk("t6_gnt0", req0_ready, 1);
    chk("t6_gnt1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
